// File: rtl/reqack_fifo_responder_pkg.sv
// Shared types and protocol notes for the req/ack FIFO responder.
// Imported by reqack_fifo_responder and its sub-blocks.
package reqack_fifo_responder_pkg;

    // req/ack pull protocol:
    //   - req is a level, held by the requester until it sees ack.
    //   - ack is a single-cycle pulse; dout carries the word on that cycle
    //     and holds it until the next ack.
    //   - ack never stays high two cycles in a row; a req still high during
    //     the ack cycle is ignored, giving the requester a cycle to drop it.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/reqack_sync_fifo.sv
// Synchronous FIFO: memory, wrap-bit pointers, full/empty and occupancy.
// No fall-through; a pushed word is readable from the following cycle.
module reqack_sync_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [data_width-1:0] wr_data,
    input  logic                  pop,
    output logic [data_width-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [addr_width:0]   level
);

    localparam logic [addr_width:0] PTR_ONE = {{addr_width{1'b0}}, 1'b1};

    logic [data_width-1:0] mem [depth];
    logic [addr_width:0]   wr_ptr;
    logic [addr_width:0]   rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[addr_width-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[addr_width-1:0]];

    // Pointers differing only in the wrap bit means every slot is in use.
    assign full  = (wr_ptr[addr_width] != rd_ptr[addr_width]) &&
                   (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/reqack_fifo_responder.sv
// Buffered req/ack responder: valid/ready push side, one-cycle ack pull side.
// Define REQACK_RESP_COUNT_EN to add the ack counter and overflow flag.
module reqack_fifo_responder #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [data_width-1:0] s_data,
    input  logic                  req,
    output logic                  ack,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   level
`ifdef REQACK_RESP_COUNT_EN
    ,
    output logic [31:0]           count,
    output logic                  overflow_err
`endif
);

    import reqack_fifo_responder_pkg::*;

    state_t                state_q;
    state_t                state_d;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [data_width-1:0] rd_data;
    logic [data_width-1:0] dout_d;

    reqack_sync_fifo #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign s_ready = ~full;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): if (req && !empty) state_d = ACK;
            (state_q == ACK):  state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        dout_d = dout;
        unique case (1'b1)
            (state_q == IDLE): begin
                pop = req && !empty;
                if (pop) dout_d = rd_data;
            end
            default: pop = 1'b0;
        endcase
    end

    // ack/dout registered so the word and its pulse leave on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack  <= 1'b0;
            dout <= '0;
        end else begin
            ack  <= pop;
            dout <= dout_d;
        end
    end

`ifdef REQACK_RESP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (pop) count <= count + 32'd1;
            if (s_valid && !s_ready) overflow_err <= 1'b1;
        end
    end
`endif

endmodule
